// File: rtl/rf_writeback_scheduler.sv
// Register-file writeback scheduler: round-robin sharing of the single RF write
// port among NUM_REQ sources, plus a pending-write scoreboard for issue hazards.
module rf_writeback_scheduler #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 5
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_rd,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic                        regWrite,
  output logic [ADDR_W-1:0]           wr_addr,
  output logic [DATA_W-1:0]           wr_data,
  input  logic                        issue_valid,
  input  logic [ADDR_W-1:0]           issue_rd,
  input  logic [ADDR_W-1:0]           issue_rs1,
  input  logic [ADDR_W-1:0]           issue_rs2,
  output logic                        stall,
  output logic [2**ADDR_W-1:0]        busy
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned NREG  = 2**ADDR_W;

  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic               regWrite_q, regWrite_d;
  logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]  wr_data_q, wr_data_d;
  logic [NREG-1:0]    busy_q, busy_d;

  logic               found;
  logic [NUM_REQ-1:0] gnt_oh;
  logic [ADDR_W-1:0]  sel_rd;
  logic [DATA_W-1:0]  sel_data;
  logic [PTR_W-1:0]   ptr_after;
  logic               hazard;

  // Scan priority offsets from the pointer; nested loops keep every index constant.
  always_comb begin
    found     = 1'b0;
    gnt_oh    = '0;
    sel_rd    = '0;
    sel_data  = '0;
    ptr_after = ptr_q;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (!found && req_valid[i] && (i == ((32'(ptr_q) + k) % NUM_REQ))) begin
          found     = 1'b1;
          gnt_oh[i] = 1'b1;
          sel_rd    = req_rd[i*ADDR_W +: ADDR_W];
          sel_data  = req_data[i*DATA_W +: DATA_W];
          ptr_after = (i == NUM_REQ - 1) ? '0 : PTR_W'(i + 1);
        end
      end
    end
  end

  assign hazard = busy_q[issue_rs1] | busy_q[issue_rs2] | busy_q[issue_rd];
  assign stall  = issue_valid & hazard;

  always_comb begin
    req_ready  = reset ? '0 : gnt_oh;
    ptr_d      = ptr_q;
    regWrite_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    if (found && !reset) begin
      ptr_d = ptr_after;
      // Writes to register 0 are accepted and dropped here.
      if (sel_rd != '0) begin
        regWrite_d = 1'b1;
        wr_addr_d  = sel_rd;
        wr_data_d  = sel_data;
      end
    end
  end

  always_comb begin
    busy_d = busy_q;
    if (regWrite_q)
      busy_d[wr_addr_q] = 1'b0;
    if (issue_valid && !hazard && (issue_rd != '0))
      busy_d[issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q      <= '0;
      regWrite_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      busy_q     <= '0;
    end else begin
      ptr_q      <= ptr_d;
      regWrite_q <= regWrite_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      busy_q     <= busy_d;
    end
  end

  assign regWrite = regWrite_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_rf_writeback_scheduler.sv
// Directed bench for rf_writeback_scheduler: expected RF writes go into a queue
// that a negedge monitor drains; grants, stall and busy are checked inline.
module tb_rf_writeback_scheduler;

  localparam int unsigned NUM_REQ = 3;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned ADDR_W  = 5;

  logic                       clk = 1'b0;
  logic                       reset;
  logic [NUM_REQ-1:0]         req_valid;
  logic [NUM_REQ*ADDR_W-1:0]  req_rd;
  logic [NUM_REQ*DATA_W-1:0]  req_data;
  logic [NUM_REQ-1:0]         req_ready;
  logic                       regWrite;
  logic [ADDR_W-1:0]          wr_addr;
  logic [DATA_W-1:0]          wr_data;
  logic                       issue_valid;
  logic [ADDR_W-1:0]          issue_rd, issue_rs1, issue_rs2;
  logic                       stall;
  logic [2**ADDR_W-1:0]       busy;

  int n_checks = 0;
  int n_fail   = 0;
  logic [ADDR_W+DATA_W-1:0] exp_q[$];

  rf_writeback_scheduler #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_rd(req_rd), .req_data(req_data), .req_ready(req_ready),
    .regWrite(regWrite), .wr_addr(wr_addr), .wr_data(wr_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .stall(stall), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [2:0] v,
                         input logic [4:0] r0, input logic [4:0] r1, input logic [4:0] r2,
                         input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2);
    req_valid = v;
    req_rd    = {r2, r1, r0};
    req_data  = {d2, d1, d0};
  endtask

  task automatic set_issue(input logic v, input logic [4:0] rd, input logic [4:0] rs1,
                           input logic [4:0] rs2);
    issue_valid = v;
    issue_rd    = rd;
    issue_rs1   = rs1;
    issue_rs2   = rs2;
  endtask

  // Check the grant and, for a non-zero destination, queue the write it must produce.
  task automatic exp_grant(input string name, input logic [2:0] exp);
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] d;
    chk(name, 64'(req_ready), 64'(exp));
    for (int i = 0; i < NUM_REQ; i++) begin
      if (exp[i]) begin
        rd = req_rd[i*ADDR_W +: ADDR_W];
        d  = req_data[i*DATA_W +: DATA_W];
        if (rd != '0) exp_q.push_back({rd, d});
      end
    end
  endtask

  initial begin : monitor
    logic [ADDR_W+DATA_W-1:0] e;
    forever begin
      @(negedge clk);
      if (regWrite === 1'b1) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_write: got addr %0d data %0h, required no write", wr_addr, wr_data);
        end else begin
          e = exp_q.pop_front();
          if ({wr_addr, wr_data} !== e) begin
            n_fail++;
            $display("FAIL rf_write: got addr %0d data %0h, required addr %0d data %0h",
                     wr_addr, wr_data, e[DATA_W +: ADDR_W], e[DATA_W-1:0]);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got timeout, required end of stimulus");
    $fatal(1, "timeout");
  end

  logic [2:0] rr1 [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};

  initial begin : stim
    reset = 1'b1;
    set_req(3'b111, 5'd1, 5'd2, 5'd3, 32'hA, 32'hB, 32'hC);
    set_issue(1'b0, '0, '0, '0);
    tick(); tick();
    // reset state, requests pending but reset still high
    #1;
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_regwrite", 64'(regWrite), 64'd0);
    chk("rst_wr_addr", 64'(wr_addr), 64'd0);
    chk("rst_wr_data", 64'(wr_data), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    tick();

    // all three requesters continuously valid
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      #1;
      exp_grant("rr_all", rr1[c]);
      if (c != 0) chk("rr_regwrite", 64'(regWrite), 64'd1);
      tick();
    end

    // requester 2 alone, then 0 and 2
    set_req(3'b100, 5'd0, 5'd0, 5'd4, 32'h0, 32'h0, 32'h22);
    for (int c = 0; c < 3; c++) begin
      #1; exp_grant("only2", 3'b100); tick();
    end
    set_req(3'b101, 5'd6, 5'd0, 5'd4, 32'h60, 32'h0, 32'h22);
    #1; exp_grant("wrap_to0", 3'b001); tick();
    set_req(3'b100, 5'd6, 5'd0, 5'd4, 32'h60, 32'h0, 32'h22);
    #1; exp_grant("then2", 3'b100); tick();
    set_req(3'b000, '0, '0, '0, '0, '0, '0);
    #1; tick();

    // RAW on register 5
    set_issue(1'b1, 5'd5, 5'd0, 5'd0);
    #1; chk("issue5_stall", 64'(stall), 64'd0); tick();
    set_issue(1'b1, 5'd0, 5'd5, 5'd0);
    set_req(3'b010, 5'd0, 5'd5, 5'd0, 32'h0, 32'hDEADBEEF, 32'h0);
    #1;
    chk("busy5_set", 64'(busy[5]), 64'd1);
    chk("raw_stall", 64'(stall), 64'd1);
    exp_grant("grant1_rd5", 3'b010);
    tick();
    set_req(3'b000, '0, '0, '0, '0, '0, '0);
    #1;
    chk("raw_stall_wb", 64'(stall), 64'd1);
    chk("wb5_regwrite", 64'(regWrite), 64'd1);
    chk("wb5_data", 64'(wr_data), 64'hDEADBEEF);
    tick();
    #1;
    chk("busy5_clr", 64'(busy[5]), 64'd0);
    chk("raw_released", 64'(stall), 64'd0);
    tick();

    // register 0 request and issue
    set_issue(1'b1, 5'd0, 5'd0, 5'd0);
    set_req(3'b001, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFF, 32'h0, 32'h0);
    #1;
    exp_grant("grant_rd0", 3'b001);
    chk("rs0_stall", 64'(stall), 64'd0);
    tick();
    set_req(3'b000, '0, '0, '0, '0, '0, '0);
    set_issue(1'b0, '0, '0, '0);
    #1;
    chk("rd0_no_write", 64'(regWrite), 64'd0);
    chk("rd0_busy", 64'(busy), 64'd0);
    tick();

    // WAW on register 7
    set_issue(1'b1, 5'd7, 5'd0, 5'd0);
    #1; chk("issue7_stall", 64'(stall), 64'd0); tick();
    set_req(3'b100, 5'd0, 5'd0, 5'd7, 32'h0, 32'h0, 32'h77);
    #1;
    chk("waw_stall", 64'(stall), 64'd1);
    exp_grant("grant2_rd7", 3'b100);
    tick();
    set_req(3'b000, '0, '0, '0, '0, '0, '0);
    #1;
    chk("waw_stall_wb", 64'(stall), 64'd1);
    chk("wb7_regwrite", 64'(regWrite), 64'd1);
    tick();
    #1;
    chk("waw_released", 64'(stall), 64'd0);
    chk("busy7_clr", 64'(busy[7]), 64'd0);
    tick();

    // reset with busy[3] set and a request in flight
    set_issue(1'b1, 5'd3, 5'd0, 5'd0);
    set_req(3'b001, 5'd8, 5'd0, 5'd0, 32'h88, 32'h0, 32'h0);
    #1;
    chk("issue3_stall", 64'(stall), 64'd0);
    chk("busy7_reset_pre", 64'(busy[7]), 64'd1);
    exp_grant("grant0_rd8", 3'b001);
    tick();
    set_issue(1'b0, '0, '0, '0);
    reset = 1'b1;
    set_req(3'b010, 5'd0, 5'd3, 5'd0, 32'h0, 32'h33, 32'h0);
    #1;
    chk("busy3_pre", 64'(busy[3]), 64'd1);
    exp_grant("ready_in_reset", 3'b000);
    tick();
    reset = 1'b0;
    set_req(3'b111, 5'd10, 5'd11, 5'd12, 32'hA0, 32'hB0, 32'hC0);
    #1;
    chk("post_rst_busy", 64'(busy), 64'd0);
    chk("post_rst_regwrite", 64'(regWrite), 64'd0);
    chk("post_rst_wr_addr", 64'(wr_addr), 64'd0);
    chk("post_rst_wr_data", 64'(wr_data), 64'd0);
    exp_grant("ptr_after_reset", 3'b001);
    tick();
    set_req(3'b000, '0, '0, '0, '0, '0, '0);
    tick(); tick();
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rf_writeback_scheduler.md
Name: rf_writeback_scheduler

Overview:
- Shares the single register-file write port (regWrite, write address, write data) among NUM_REQ writeback sources (ALU, load unit, multiplier), using round-robin arbitration.
- Keeps a per-register pending-write scoreboard and raises an issue stall on RAW/WAW hazards.
- Sits between the execute/memory units and the 32 x 32-bit register file, whose registers each take clk, reset and a regWrite enable.

Parameters:
NUM_REQ, 3, number of writeback requesters
DATA_W, 32, register data width
ADDR_W, 5, register index width (2**ADDR_W registers)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
req_valid  input  NUM_REQ  per-requester writeback request
req_rd  input  NUM_REQ*ADDR_W  destination index; requester i uses bits [i*ADDR_W +: ADDR_W]
req_data  input  NUM_REQ*DATA_W  write data; requester i uses bits [i*DATA_W +: DATA_W]
req_ready  output  NUM_REQ  one-hot grant; a transfer occurs when valid&ready
regWrite  output  1  register-file write enable (registered)
wr_addr  output  ADDR_W  register-file write index (registered)
wr_data  output  DATA_W  register-file write data (registered)
issue_valid  input  1  decode wants to issue an instruction
issue_rd  input  ADDR_W  destination of the issuing instruction
issue_rs1  input  ADDR_W  source 1 of the issuing instruction
issue_rs2  input  ADDR_W  source 2 of the issuing instruction
stall  output  1  issue blocked by a hazard (combinational)
busy  output  2**ADDR_W  scoreboard vector; bit r = write to r pending

Behaviour:
- One clock (clk); reset is synchronous and active-high.
- Reset state (applied at the clk edge while reset=1):
  - regWrite=0, wr_addr=0, wr_data=0, busy=0.
  - Round-robin pointer = 0.
  - req_ready=0 while reset is high.
  - A reset mid-operation discards any in-flight write and all pending bits. Nothing is written on that edge.
- Arbitration (combinational):
  - Scan requesters starting at the pointer, upward with wrap-around.
  - The first i with req_valid[i]=1 gets req_ready[i]=1; all others get 0.
  - No valid requests gives req_ready=0.
  - req_ready never depends on a requester's own data.
- Pointer update:
  - On a grant to i, pointer <= (i+1) mod NUM_REQ.
  - With no grant, the pointer holds.
  - At most one transfer per cycle.
- Write latency is 1 cycle. At the edge after an accepted request:
  - regWrite=1, wr_addr=rd, wr_data=data.
  - With no transfer, regWrite=0 and wr_addr/wr_data hold their last values.
- Register 0 is hardwired:
  - A request with rd=0 is accepted (ready asserted, requester freed), but regWrite stays 0.
  - busy[0] is constantly 0.
- Scoreboard:
  - hazard = busy[issue_rs1] | busy[issue_rs2] | busy[issue_rd]. A busy[0] term is always 0.
  - stall = issue_valid & hazard.
  - When issue_valid=1, stall=0 and issue_rd!=0, then busy[issue_rd] <= 1 at the edge.
  - A stalled issue records nothing; decode holds the issue and retries.
  - busy[r] <= 0 on the edge at the end of a cycle in which regWrite=1 and wr_addr=r. The bit is still 1 during that cycle, so a same-index issue stalls exactly through it. A same-bit set and clear therefore never coincide.
  - A writeback to a non-busy register still writes; busy is unchanged.
  - Set and clear of different bits in the same edge both take effect.
- Requesters must hold req_valid/req_rd/req_data stable until accepted. The block does not buffer beyond the single output stage.

Test Plan:
- Reset, then all three requesters valid continuously with rd=1/2/3 and data A/B/C:
  - Grants rotate 0,1,2,0,...
  - regWrite=1 each cycle from cycle 2 with wr_addr 1,2,3,...
- Only requester 2 valid for 3 cycles, then requesters 0 and 2 valid:
  - Pointer wraps to 0 after the first grant, so 0 is granted next, then 2.
- Issue rd=5, then on the next cycle issue rs1=5:
  - busy[5]=1 and stall=1.
  - Requester 1 writes rd=5 with 0xDEADBEEF: regWrite cycle shows wr_data=0xDEADBEEF, stall still 1.
  - Next cycle busy[5]=0 and stall=0.
- Request with rd=0 and data 0xFFFFFFFF:
  - req_ready=1 and regWrite stays 0.
  - Issue rd=0 does not set any busy bit; issue rs1=0 never stalls.
- Issue rd=7 (accepted), then issue rd=7 again:
  - Second issue stalls (WAW) until the rd=7 writeback clears busy[7].
- Assert reset for 1 cycle while busy[3]=1 and a grant is in flight:
  - Next cycle busy=0, regWrite=0, pointer=0, and no write of the in-flight data.
